// File: rtl/spi_slave.sv
// SPI slave (modes 0..3, multi-word bursts) oversampled in the clk domain.
// Optional SPI_SLAVE_RX_OVERRUN_EN adds rx_ack / rx_overrun receive-overrun tracking.
module spi_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_WIDTH-1:0] tx_byte,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  rx_valid,
  output logic                  busy
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  ,
  input  logic                  rx_ack,
  output logic                  rx_overrun
`endif
);

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                r_state, w_next_state;
  logic [2:0]            r_sclk_sync, r_ss_sync;
  logic [1:0]            r_mosi_sync;
  logic [DATA_WIDTH-1:0] r_shift, r_rx_shift, r_rx_byte, r_tx_buf;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_miso, r_rx_valid, r_tx_ready;

  logic                  w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic                  w_lead, w_trail, w_reload, w_sample, w_advance, w_tx_take;
  logic                  w_stop;
  logic [DATA_WIDTH-1:0] w_reload_word;

  // [0] and [1] synchronise, [2] is the history bit used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_ss_sync   <= {r_ss_sync[1:0], ss_n};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_ss_fall   = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_rise   = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_lead      = cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = cpol ? w_sclk_rise : w_sclk_fall;
  assign w_tx_take   = tx_load & r_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_reload     = 1'b0;
    w_sample     = 1'b0;
    w_advance    = 1'b0;
    w_stop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_next_state = S_SHIFT;
          w_reload     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_ss_rise) begin
          w_next_state = S_IDLE;
          w_stop       = 1'b1;
        end else begin
          // The rx_valid cycle doubles as the reload slot so a tx_load answering
          // rx_valid lands directly in the next word.
          w_reload  = r_rx_valid;
          w_sample  = cpha ? w_trail : w_lead;
          w_advance = cpha ? w_lead : (w_trail & (r_bit_cnt != '0));
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_reload_word = IDLE_BYTE;
    if (w_tx_take)        w_reload_word = tx_byte;
    else if (!r_tx_ready) w_reload_word = r_tx_buf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_tx_buf   <= '0;
      r_bit_cnt  <= '0;
      r_miso     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_advance) begin
        if (cpha) begin
          r_miso  <= r_shift[DATA_WIDTH-1];
          r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
          r_miso  <= r_shift[DATA_WIDTH-2];
          r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync[1]};
        if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
          r_bit_cnt  <= '0;
          r_rx_byte  <= {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync[1]};
          r_rx_valid <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
      if (w_reload) begin
        r_shift    <= w_reload_word;
        r_tx_ready <= 1'b1;
        if (!cpha) r_miso <= w_reload_word[DATA_WIDTH-1];
        if (r_state == S_IDLE) begin
          r_bit_cnt <= '0;
          if (cpha) r_miso <= 1'b0;
        end
      end else if (w_tx_take) begin
        r_tx_buf   <= tx_byte;
        r_tx_ready <= 1'b0;
      end
      if (w_stop) begin
        r_miso    <= 1'b0;
        r_bit_cnt <= '0;
      end
    end
  end

`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic r_pending, r_rx_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_rx_overrun <= 1'b0;
    end else if (r_rx_valid) begin
      r_pending <= 1'b1;
      if (r_pending) r_rx_overrun <= 1'b1;
    end else if (rx_ack) begin
      r_pending    <= 1'b0;
      r_rx_overrun <= 1'b0;
    end
  end

  assign rx_overrun = r_rx_overrun;
`endif

  assign busy     = (r_state == S_SHIFT);
  assign miso_oe  = (r_state == S_SHIFT);
  assign miso     = r_miso;
  assign tx_ready = r_tx_ready;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: the bench plays the SPI master and checks both directions.
// Build with +define+SPI_SLAVE_RX_OVERRUN_EN to add the overrun scenario.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sclk = 1'b0;
  logic       ssN = 1'b1;
  logic       mosi = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] txByte = 8'h00;
  logic       txLoad = 1'b0;
  logic       miso, misoOe, txReady, rxValid, busy;
  logic [7:0] rxByte;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic       rxAck = 1'b0;
  logic       rxOverrun;
`endif

  int         errors = 0;
  int         checks = 0;
  int         rxCount = 0;
  logic [7:0] rxLog[$];

  spi_slave #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rstN), .sclk(sclk), .ss_n(ssN), .mosi(mosi),
    .miso(miso), .miso_oe(misoOe), .cpol(cpol), .cpha(cpha),
    .tx_byte(txByte), .tx_load(txLoad), .tx_ready(txReady),
    .rx_byte(rxByte), .rx_valid(rxValid), .busy(busy)
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    , .rx_ack(rxAck), .rx_overrun(rxOverrun)
`endif
  );

  always #5 clk = ~clk;

  // Log every cycle rx_valid is high; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (rxValid) begin
      rxCount++;
      rxLog.push_back(rxByte);
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadTx(input logic [7:0] b);
    @(negedge clk);
    txByte = b;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
  endtask

  task automatic setMode(input int m);
    @(negedge clk);
    cpol = m[1];
    cpha = m[0];
    sclk = cpol;
    waitClk(6);
  endtask

  task automatic select();
    ssN = 1'b0;
    waitClk(4);
  endtask

  task automatic deselect();
    waitClk(4);
    ssN = 1'b1;
    waitClk(6);
  endtask

  // Master side of n bits, MSB first, half period of 4 clk.
  task automatic spiBits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        waitClk(4);
        mi[i] = miso;
        sclk = ~cpol;
        waitClk(4);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[i];
        waitClk(4);
        mi[i] = miso;
        sclk = cpol;
        waitClk(4);
      end
    end
    waitClk(4);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    waitClk(3);
    rstN = 1'b1;
    waitClk(3);
    checks++; if (miso !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
    checks++; if (misoOe !== 1'b0) begin errors++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", misoOe); end
    checks++; if (rxByte !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_byte: got %h expected 00", rxByte); end
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rxValid); end
    checks++; if (txReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", txReady); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mode0();
    logic [7:0] mi;
    int base;
    loadTx(8'h3C);
    checks++; if (txReady !== 1'b0) begin errors++; $display("[TB] FAIL mode0_tx_ready_after_load: got %b expected 0", txReady); end
    checks++; if (misoOe !== 1'b0) begin errors++; $display("[TB] FAIL mode0_oe_before: got %b expected 0", misoOe); end
    base = rxCount;
    select();
    checks++; if ({busy, misoOe} !== 2'b11) begin errors++; $display("[TB] FAIL mode0_busy_oe: got %b expected 11", {busy, misoOe}); end
    spiBits(8'hA5, 8, mi);
    deselect();
    checks++; if (rxByte !== 8'hA5) begin errors++; $display("[TB] FAIL mode0_rx: got %h expected a5", rxByte); end
    checks++; if (rxCount - base !== 1) begin errors++; $display("[TB] FAIL mode0_pulses: got %0d expected 1", rxCount - base); end
    checks++; if (mi !== 8'h3C) begin errors++; $display("[TB] FAIL mode0_miso: got %h expected 3c", mi); end
    checks++; if (misoOe !== 1'b0) begin errors++; $display("[TB] FAIL mode0_oe_after: got %b expected 0", misoOe); end
  endtask

  task automatic test_modes();
    logic [7:0] mi;
    int base;
    for (int m = 1; m < 4; m++) begin
      setMode(m);
      loadTx(8'hC3);
      base = rxCount;
      select();
      spiBits(8'h5A, 8, mi);
      deselect();
      checks++; if (rxByte !== 8'h5A) begin errors++; $display("[TB] FAIL mode%0d_rx: got %h expected 5a", m, rxByte); end
      checks++; if (mi !== 8'hC3) begin errors++; $display("[TB] FAIL mode%0d_miso: got %h expected c3", m, mi); end
      checks++; if (rxCount - base !== 1) begin errors++; $display("[TB] FAIL mode%0d_pulses: got %0d expected 1", m, rxCount - base); end
    end
    setMode(0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi0, mi1;
    int base;
    bit seen;
    seen = 1'b0;
    loadTx(8'h33);
    base = rxCount;
    select();
    fork
      spiBits(8'h11, 8, mi0);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (rxValid) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          txByte = 8'h44;
          txLoad = 1'b1;
          @(negedge clk);
          txLoad = 1'b0;
        end
      end
    join
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_valid: got %b expected 1 within 200 clk", seen); end
    checks++; if (txReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_tx_ready_direct: got %b expected 1", txReady); end
    spiBits(8'h22, 8, mi1);
    deselect();
    checks++; if (mi0 !== 8'h33) begin errors++; $display("[TB] FAIL b2b_miso0: got %h expected 33", mi0); end
    checks++; if (mi1 !== 8'h44) begin errors++; $display("[TB] FAIL b2b_miso1: got %h expected 44", mi1); end
    checks++; if (rxCount - base !== 2) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 2", rxCount - base); end
    if (rxCount - base == 2) begin
      checks++; if (rxLog[base] !== 8'h11) begin errors++; $display("[TB] FAIL b2b_rx0: got %h expected 11", rxLog[base]); end
      checks++; if (rxLog[base + 1] !== 8'h22) begin errors++; $display("[TB] FAIL b2b_rx1: got %h expected 22", rxLog[base + 1]); end
    end
  endtask

  task automatic test_empty_buffer();
    logic [7:0] mi;
    select();
    spiBits(8'h00, 8, mi);
    deselect();
    checks++; if (mi !== 8'hFF) begin errors++; $display("[TB] FAIL empty_idle_byte: got %h expected ff", mi); end
    loadTx(8'h12);
    loadTx(8'h77);
    checks++; if (txReady !== 1'b0) begin errors++; $display("[TB] FAIL empty_tx_ready_full: got %b expected 0", txReady); end
    select();
    spiBits(8'h00, 8, mi);
    deselect();
    checks++; if (mi !== 8'h12) begin errors++; $display("[TB] FAIL empty_load_ignored: got %h expected 12", mi); end
    checks++; if (txReady !== 1'b1) begin errors++; $display("[TB] FAIL empty_tx_ready_consumed: got %b expected 1", txReady); end
  endtask

  task automatic test_abort_reset();
    logic [7:0] mi;
    int base;
    base = rxCount;
    select();
    spiBits(8'hE0, 3, mi);
    deselect();
    checks++; if (rxCount !== base) begin errors++; $display("[TB] FAIL abort_no_valid: got %0d pulses expected 0", rxCount - base); end
    checks++; if ({busy, misoOe, miso} !== 3'b000) begin errors++; $display("[TB] FAIL abort_idle: got %b expected 000", {busy, misoOe, miso}); end
    select();
    spiBits(8'h81, 8, mi);
    deselect();
    checks++; if (rxByte !== 8'h81) begin errors++; $display("[TB] FAIL abort_next_rx: got %h expected 81", rxByte); end
    checks++; if (rxCount - base !== 1) begin errors++; $display("[TB] FAIL abort_next_pulses: got %0d expected 1", rxCount - base); end
    loadTx(8'h0F);
    select();
    spiBits(8'hF0, 4, mi);
    #3 rstN = 1'b0;
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_miso: got %b expected 0", miso); end
    checks++; if ({busy, misoOe} !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_busy_oe: got %b expected 00", {busy, misoOe}); end
    checks++; if (rxByte !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_rx_byte: got %h expected 00", rxByte); end
    checks++; if ({txReady, rxValid} !== 2'b10) begin errors++; $display("[TB] FAIL rst_mid_ready_valid: got %b expected 10", {txReady, rxValid}); end
    ssN = 1'b1;
    sclk = cpol;
    waitClk(3);
    rstN = 1'b1;
    waitClk(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_busy: got %b expected 0", busy); end
  endtask

`ifdef SPI_SLAVE_RX_OVERRUN_EN
  task automatic test_overrun();
    logic [7:0] mi;
    @(negedge clk);
    rxAck = 1'b1;
    @(negedge clk);
    rxAck = 1'b0;
    checks++; if (rxOverrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_initial: got %b expected 0", rxOverrun); end
    select();
    spiBits(8'h01, 8, mi);
    checks++; if (rxOverrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_one_word: got %b expected 0", rxOverrun); end
    spiBits(8'h02, 8, mi);
    deselect();
    checks++; if (rxOverrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_set: got %b expected 1", rxOverrun); end
    checks++; if (rxByte !== 8'h02) begin errors++; $display("[TB] FAIL ovr_rx_overwritten: got %h expected 02", rxByte); end
    @(negedge clk);
    rxAck = 1'b1;
    @(negedge clk);
    rxAck = 1'b0;
    checks++; if (rxOverrun !== 1'b0) begin errors++; $display("[TB] FAIL ovr_cleared: got %b expected 0", rxOverrun); end
  endtask
`endif

  initial begin
    $display("[TB] spi_slave bench start");
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_empty_buffer();
    test_abort_reset();
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    test_overrun();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (target) that is the far end of the team's SPI master. Supports CPOL/CPHA modes 0..3 and multi-byte bursts while ss_n stays low.
- sclk, ss_n and mosi are asynchronous pins. They are oversampled in the system clk domain with 2-flop synchronizers and edge detection. No logic runs on sclk itself.
- Presents received bytes with a one-cycle valid pulse. Accepts the next transmit byte through a single-entry buffer with a ready/load handshake.

Parameters:
- DATA_WIDTH, 8, bits per transfer word (>=2)
- IDLE_BYTE, all ones (DATA_WIDTH bits), word shifted out when the tx buffer is empty at word start

Ports:
- clk  input  1  system clock; must be >= 8x SCLK frequency (master half period >= 4 clk)
- rst_n  input  1  asynchronous active-low reset
- sclk  input  1  SPI clock pin (async)
- ss_n  input  1  SPI select pin, active low (async)
- mosi  input  1  SPI data in (async)
- miso  output  1  SPI data out
- miso_oe  output  1  MISO drive enable; high only while selected
- cpol  input  1  clock polarity; change only while ss_n is high
- cpha  input  1  clock phase; change only while ss_n is high
- tx_byte  input  DATA_WIDTH  next word to transmit
- tx_load  input  1  capture tx_byte into the tx buffer (honoured only when tx_ready=1)
- tx_ready  output  1  tx buffer empty
- rx_byte  output  DATA_WIDTH  last complete received word, MSB first on the wire
- rx_valid  output  1  one-cycle pulse when rx_byte updates
- busy  output  1  high while selected (synced ss_n low)

Behaviour:
- Reset (rst_n low, async): miso=0, miso_oe=0, rx_byte=0, rx_valid=0, tx_ready=1, busy=0, bit counter=0, state IDLE.
- Sync: 2 flops per pin, plus a third history flop on sclk and ss_n for edge detection. Pin-to-detected-edge delay is 2-3 clk.
- Edge classification: leading edge = synced sclk moving away from cpol; trailing edge = moving back to cpol.
- State IDLE: miso_oe=0, busy=0. On synced ss_n falling edge, go to SHIFT:
  - load the shift register from the tx buffer, or IDLE_BYTE if the buffer is empty;
  - set tx_ready=1 (buffer consumed);
  - clear bit count; busy=1, miso_oe=1.
  - If cpha=0, miso = shift MSB in the same cycle.
- State SHIFT, cpha=0: sample mosi on leading edge; on trailing edge shift the tx register left and drive the next MSB on miso.
- State SHIFT, cpha=1: on leading edge drive the current MSB (first leading edge drives bit DATA_WIDTH-1) and then shift; sample mosi on trailing edge.
- Word complete on the DATA_WIDTH-th sample:
  - next clk: rx_byte = assembled word, rx_valid=1 for exactly one clk; bit count returns to 0;
  - shift register reloads from the tx buffer (or IDLE_BYTE); tx_ready=1;
  - cpha=0: the reloaded MSB is driven on miso at the reload cycle. Burst continues.
- tx_load with tx_ready=1 captures tx_byte; tx_ready falls next clk. tx_load with tx_ready=0 is ignored; the buffer keeps its value.
- tx_load in the same clk as a word-start reload: tx_byte goes straight into the shift register and tx_ready stays 1.
- Synced ss_n rising in SHIFT (abort or normal end): return to IDLE next clk, miso_oe=0, miso=0, partial word discarded, no rx_valid. A complete word whose rx_valid coincides with ss_n rising is still reported.
- A sclk edge in the same clk as ss_n falling is ignored.
- rx_byte holds its value until the next word completes. rx_valid never asserts in IDLE.

Optional Feature:
- Macro SPI_SLAVE_RX_OVERRUN_EN.
- Defined: adds input rx_ack (1) and output rx_overrun (1, reset 0).
  - A word is pending from rx_valid until rx_ack.
  - A new rx_valid while still pending sets rx_overrun sticky; rx_byte is still overwritten.
  - rx_ack with no new rx_valid in the same clk clears pending and rx_overrun.
- Undefined: no extra ports; every rx_valid simply overwrites rx_byte.

Test Plan:
- Mode 0, half period 4 clk, master sends 0xA5, slave preloaded 0x3C -> rx_byte=0xA5 with one rx_valid pulse; master receives 0x3C; miso_oe low before and after ss_n.
- Modes 1, 2, 3 each: master 0x5A, slave 0xC3 -> rx_byte=0x5A, master receives 0xC3 in every mode.
- Mode 0 burst of 0x11 then 0x22, with 0x33 loaded at reset and 0x44 loaded after the first rx_valid -> two rx_valid pulses (0x11, 0x22); master receives 0x33, 0x44.
- Tx buffer empty at select -> master receives 0xFF; tx_load of 0x77 while tx_ready=0 is ignored.
- ss_n raised after 3 bits, then a full transfer of 0x81 -> no rx_valid for the aborted word; next rx_byte=0x81. Async rst_n pulse mid-word -> all outputs return to reset values.
- With SPI_SLAVE_RX_OVERRUN_EN: two words, no rx_ack -> rx_overrun=1 after the second rx_valid; rx_ack clears it to 0.
